// File: rtl/tx_rr_arbiter_pkg.sv
// Shared constants for the UART TX round-robin arbiter: FSM state encoding
// and the timeout counter width helper.
package tx_rr_arbiter_pkg;

  // FSM state encoding; values are fixed so other uart_dualwatch blocks can decode them.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_t;

  // Counter width that holds 0 .. cyc-1 without overflow (at least 1 bit).
  function automatic int cnt_width(input int cyc);
    return (cyc > 1) ? $clog2(cyc) : 1;
  endfunction

endpackage

// File: rtl/mux_selN.sv
// Generic N:1 mux over a flattened bus; lane i sits at [IN_WIDTH*i +: IN_WIDTH].
module mux_selN #(
  parameter int SEL_WIDTH = 2,
  parameter int IN_WIDTH  = 8
) (
  input  logic [SEL_WIDTH-1:0]               sel,
  input  logic [IN_WIDTH*(2**SEL_WIDTH)-1:0] din,
  output logic [IN_WIDTH-1:0]                dout
);

  localparam int N = 2**SEL_WIDTH;

  logic [IN_WIDTH-1:0] lanes [N];

  for (genvar g = 0; g < N; g++) begin : g_lane
    assign lanes[g] = din[IN_WIDTH*g +: IN_WIDTH];
  end

  assign dout = lanes[sel];

endmodule

// File: rtl/tx_rr_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N requesters.
// Handshake: a requester holds req[i] high as a level; once it owns the
// transmitter (grant[i]) the transfer runs to completion even if req[i]
// drops, and ends with a one-cycle ack[i] on tx_done or on WAIT timeout.
// tx_start is a one-cycle pulse; tx_data is held from tx_start to tx_done.
module tx_rr_arbiter
  import tx_rr_arbiter_pkg::*;
#(
  parameter int SEL_WIDTH   = 2,
  parameter int DATA_WIDTH  = 8,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [(2**SEL_WIDTH)-1:0]            req,
  input  logic [DATA_WIDTH*(2**SEL_WIDTH)-1:0] req_data,
  input  logic                                 tx_busy,
  input  logic                                 tx_done,
  output logic                                 tx_start,
  output logic [DATA_WIDTH-1:0]                tx_data,
  output logic [SEL_WIDTH-1:0]                 sel,
  output logic [(2**SEL_WIDTH)-1:0]            grant,
  output logic [(2**SEL_WIDTH)-1:0]            ack,
  output logic                                 timeout,
  output arb_state_t                           dbg_state
);

  localparam int N     = 2**SEL_WIDTH;
  localparam int CNT_W = cnt_width(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  arb_state_t           state, state_nxt;
  logic [SEL_WIDTH-1:0] ptr, ptr_nxt;
  logic [SEL_WIDTH-1:0] sel_nxt;
  logic [N-1:0]         grant_nxt, ack_nxt;
  logic                 tx_start_nxt, timeout_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic                 pick_valid;
  logic [SEL_WIDTH-1:0] pick_idx;

  // Round-robin pick: first set req bit at or after ptr, wrapping modulo N.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = ptr;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[ptr + SEL_WIDTH'(i)]) begin
        pick_valid = 1'b1;
        pick_idx   = ptr + SEL_WIDTH'(i);
      end
    end
  end

  // Next-state and next-output logic; outputs are registered so they are glitch-free.
  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    sel_nxt      = sel;
    grant_nxt    = grant;
    ack_nxt      = '0;
    tx_start_nxt = 1'b0;
    timeout_nxt  = 1'b0;
    cnt_nxt      = cnt;
    case (state)
      ST_IDLE: begin
        if (pick_valid && !tx_busy) begin
          sel_nxt            = pick_idx;
          grant_nxt          = '0;
          grant_nxt[pick_idx] = 1'b1;
          state_nxt          = ST_START;
        end
      end
      ST_START: begin
        tx_start_nxt = 1'b1;
        cnt_nxt      = '0;
        state_nxt    = ST_WAIT;
      end
      ST_WAIT: begin
        // tx_done wins over a coinciding expiry, so timeout is only flagged without it.
        if (tx_done || (cnt == CNT_LAST)) begin
          ack_nxt      = '0;
          ack_nxt[sel] = 1'b1;
          timeout_nxt  = !tx_done;
          ptr_nxt      = sel + SEL_WIDTH'(1);
          grant_nxt    = '0;
          state_nxt    = ST_IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        grant_nxt = '0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset drops ownership without acking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      sel      <= '0;
      grant    <= '0;
      ack      <= '0;
      tx_start <= 1'b0;
      timeout  <= 1'b0;
      cnt      <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      sel      <= sel_nxt;
      grant    <= grant_nxt;
      ack      <= ack_nxt;
      tx_start <= tx_start_nxt;
      timeout  <= timeout_nxt;
      cnt      <= cnt_nxt;
    end
  end

  assign dbg_state = state;

  // tx_data follows the registered owner, so it cannot move during a transfer.
  mux_selN #(
    .SEL_WIDTH(SEL_WIDTH),
    .IN_WIDTH (DATA_WIDTH)
  ) u_data_mux (
    .sel (sel),
    .din (req_data),
    .dout(tx_data)
  );

endmodule

// File: tb/tb_tx_rr_arbiter.sv
// Self-checking bench for tx_rr_arbiter (SEL_WIDTH=2, DATA_WIDTH=8, TIMEOUT_CYC=16).
module tb_tx_rr_arbiter;

  localparam int SW = 2;
  localparam int DW = 8;
  localparam int TO = 16;
  localparam int N  = 4;

  // ---------------- clock / reset / signals ----------------
  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [DW*N-1:0] req_data;
  logic            tx_busy;
  logic            tx_done;
  logic            tx_start;
  logic [DW-1:0]   tx_data;
  logic [SW-1:0]   sel;
  logic [N-1:0]    grant;
  logic [N-1:0]    ack;
  logic            timeout;
  logic [1:0]      dbg_state;

  int checks = 0;
  int errors = 0;
  int ptr_m  = 0;   // reference round-robin pointer

  always #5 clk = ~clk;

  tx_rr_arbiter #(
    .SEL_WIDTH  (SW),
    .DATA_WIDTH (DW),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_data (req_data),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .sel      (sel),
    .grant    (grant),
    .ack      (ack),
    .timeout  (timeout),
    .dbg_state(dbg_state)
  );

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model helpers ----------------
  function automatic logic [N-1:0] onehot(input int i);
    return N'(1) << i;
  endfunction

  // First requester at or after p, counting modulo N.
  function automatic int rr_pick(input int p, input logic [N-1:0] m);
    for (int off = 0; off < N; off++) begin
      if (m[(p + off) % N]) return (p + off) % N;
    end
    return -1;
  endfunction

  function automatic logic [DW*N-1:0] rand_data();
    return {$urandom()};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n    = 1'b0;
    req      = '0;
    tx_done  = 1'b0;
    tx_busy  = 1'b0;
    req_data = rand_data();
    repeat (3) tick();
    rst_n = 1'b1;
    ptr_m = 0;
    tick();
  endtask

  // One full transfer starting from IDLE. d = WAIT cycle carrying tx_done
  // (WAIT cycle 1 is the tx_start cycle); d > TO means no tx_done at all.
  task automatic run_txn(input logic [N-1:0] mask, input logic [DW*N-1:0] data,
                         input int d, input bit drop, output int owner);
    int            exp_owner;
    logic [DW-1:0] exp_byte;
    logic [17:0]   exp_vec;
    logic [17:0]   act_vec;
    exp_owner = rr_pick(ptr_m, mask);
    exp_byte  = data[DW*exp_owner +: DW];
    req       = mask;
    req_data  = data;
    tx_done   = 1'($urandom_range(0, 1));  // IDLE: must be ignored
    tick();
    checks++;
    if (dbg_state !== 2'd1 || grant !== onehot(exp_owner) || sel !== exp_owner[SW-1:0] || tx_start !== 1'b0) begin
      errors++;
      $display("FAIL start_phase: state=%0d grant=%b sel=%0d tx_start=%b, required state=1 grant=%b sel=%0d tx_start=0",
               dbg_state, grant, sel, tx_start, onehot(exp_owner), exp_owner);
    end
    tx_done = 1'($urandom_range(0, 1));    // START: must be ignored
    tick();
    tx_done = 1'b0;
    checks++;
    if (tx_start !== 1'b1 || tx_data !== exp_byte || grant !== onehot(exp_owner) || dbg_state !== 2'd2) begin
      errors++;
      $display("FAIL tx_start_latency: tx_start=%b tx_data=%h grant=%b state=%0d, required 1 %h %b 2",
               tx_start, tx_data, grant, dbg_state, exp_byte, onehot(exp_owner));
    end
    if (drop) req = '0;
    for (int k = 1; k <= TO; k++) begin
      tx_done = (k == d);
      tick();
      tx_done = 1'b0;
      if (k == d || k == TO) begin
        exp_vec = {onehot(exp_owner), (d > TO), 1'b0, {N{1'b0}}, exp_byte};
        act_vec = {ack, timeout, tx_start, grant, exp_byte};
        checks++;
        if (act_vec !== exp_vec || dbg_state !== 2'd0) begin
          errors++;
          $display("FAIL completion(k=%0d d=%0d): ack=%b timeout=%b tx_start=%b grant=%b state=%0d, required ack=%b timeout=%b tx_start=0 grant=0 state=0",
                   k, d, ack, timeout, tx_start, grant, dbg_state, onehot(exp_owner), (d > TO));
        end
        break;
      end else begin
        exp_vec = {{N{1'b0}}, 1'b0, 1'b0, onehot(exp_owner), exp_byte};
        act_vec = {ack, timeout, tx_start, grant, tx_data};
        checks++;
        if (act_vec !== exp_vec) begin
          errors++;
          $display("FAIL wait_hold(k=%0d): {ack,timeout,tx_start,grant,tx_data}=%h, required %h", k, act_vec, exp_vec);
        end
      end
    end
    ptr_m = (exp_owner + 1) % N;
    owner = exp_owner;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n    = 1'b0;
    req      = 4'b1111;
    tx_done  = 1'b0;
    tx_busy  = 1'b0;
    req_data = 32'hDEAD_BE5A;
    repeat (3) tick();
    checks++;
    if (grant !== '0 || ack !== '0 || tx_start !== 1'b0 || timeout !== 1'b0 || sel !== '0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs: grant=%b ack=%b tx_start=%b timeout=%b sel=%0d state=%0d, required all 0",
               grant, ack, tx_start, timeout, sel, dbg_state);
    end
    checks++;
    if (tx_data !== 8'h5A) begin
      errors++;
      $display("FAIL reset_tx_data: got %h required 5a", tx_data);
    end
    req   = '0;
    rst_n = 1'b1;
    ptr_m = 0;
    tick();
  endtask

  task automatic test_single();
    int owner;
    apply_reset();
    run_txn(4'b0010, 32'h0000_A500, 4, 1'b0, owner);
    checks++;
    if (owner != 1) begin
      errors++;
      $display("FAIL single_owner: model owner %0d required 1", owner);
    end
    // pointer now 2: all requesting must go to requester 2
    run_txn(4'b1111, rand_data(), 3, 1'b0, owner);
    checks++;
    if (grant !== '0 || owner != 2) begin
      errors++;
      $display("FAIL ptr_after_single: owner %0d grant=%b, required owner 2 grant 0", owner, grant);
    end
    req = '0;
  endtask

  task automatic test_round_robin();
    int owner;
    int order [5] = '{0, 1, 2, 3, 0};
    apply_reset();
    for (int t = 0; t < 5; t++) begin
      run_txn(4'b1111, 32'h3322_1100, 10, 1'b0, owner);
      checks++;
      if (owner != order[t]) begin
        errors++;
        $display("FAIL rr_order[%0d]: owner %0d required %0d", t, owner, order[t]);
      end
    end
    req = '0;
  endtask

  task automatic test_wrap();
    int owner;
    apply_reset();
    run_txn(4'b0100, rand_data(), 2, 1'b0, owner);   // leaves pointer at 3
    run_txn(4'b1001, rand_data(), 2, 1'b0, owner);
    checks++;
    if (owner != 3) begin
      errors++;
      $display("FAIL wrap_first: owner %0d required 3", owner);
    end
    run_txn(4'b1001, rand_data(), 2, 1'b0, owner);
    checks++;
    if (owner != 0) begin
      errors++;
      $display("FAIL wrap_second: owner %0d required 0", owner);
    end
    req = '0;
  endtask

  task automatic test_timeout();
    int owner;
    apply_reset();
    run_txn(4'b0001, rand_data(), TO + 4, 1'b1, owner);  // no tx_done, req dropped
    run_txn(4'b0011, rand_data(), TO, 1'b0, owner);      // tx_done on expiry cycle
    checks++;
    if (owner != 1) begin
      errors++;
      $display("FAIL timeout_ptr_advance: owner %0d required 1", owner);
    end
    run_txn(4'b1111, rand_data(), 1, 1'b0, owner);       // shortest transfer
    req = '0;
  endtask

  task automatic test_reset_mid_wait();
    int owner;
    apply_reset();
    req      = 4'b0001;
    req_data = rand_data();
    tick();             // START
    tick();             // WAIT 1
    tick();             // WAIT 2
    tick();             // WAIT 3
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (grant !== '0 || ack !== '0 || tx_start !== 1'b0 || timeout !== 1'b0 || sel !== '0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid_wait: grant=%b ack=%b tx_start=%b timeout=%b sel=%0d state=%0d, required all 0",
               grant, ack, tx_start, timeout, sel, dbg_state);
    end
    req = '0;
    repeat (2) begin
      tick();
      checks++;
      if (ack !== '0) begin
        errors++;
        $display("FAIL reset_no_ack: ack=%b required 0", ack);
      end
    end
    rst_n = 1'b1;
    ptr_m = 0;
    tick();
    run_txn(4'b0100, rand_data(), 5, 1'b0, owner);
    checks++;
    if (owner != 2) begin
      errors++;
      $display("FAIL after_reset_grant: owner %0d required 2", owner);
    end
    req = '0;
  endtask

  task automatic test_busy();
    int owner;
    req      = 4'b0010;
    req_data = rand_data();
    tx_busy  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (tx_start !== 1'b0 || grant !== '0 || dbg_state !== 2'd0) begin
        errors++;
        $display("FAIL busy_hold[%0d]: tx_start=%b grant=%b state=%0d, required 0 0 0", c, tx_start, grant, dbg_state);
      end
    end
    tx_busy = 1'b0;
    run_txn(4'b0010, req_data, 6, 1'b0, owner);
    req = '0;
  endtask

  task automatic test_random();
    int            owner;
    int            gap;
    logic [N-1:0]  mask;
    apply_reset();
    for (int t = 0; t < 40; t++) begin
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        req = '0;
        for (int g = 0; g < gap; g++) begin
          tick();
          checks++;
          if (grant !== '0 || tx_start !== 1'b0 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL idle_gap: grant=%b tx_start=%b state=%0d, required 0 0 0", grant, tx_start, dbg_state);
          end
        end
      end
      mask = 4'($urandom_range(1, 15));
      run_txn(mask, rand_data(), $urandom_range(1, TO + 4), ($urandom_range(0, 3) == 0), owner);
    end
    req = '0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_timeout();
    test_reset_mid_wait();
    test_busy();
    test_random();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
